// File: rtl/cfu_requester.sv
// rtl/cfu_requester.sv - CFU request/response tracker with tagged slot table and writeback register.
// Optional response watchdog with error flush: define CFU_REQUESTER_TIMEOUT_EN.
module cfu_requester #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [31:0]              issue_insn,
    input  logic [31:0]              issue_rs1,
    input  logic [31:0]              issue_rs2,
    input  logic [TAG_W-1:0]         issue_tag,
    input  logic                     issue_csr,
    output logic                     cfu_req_valid,
    input  logic                     cfu_req_ready,
    output logic [31:0]              cfu_req_insn,
    output logic [31:0]              cfu_req_data0,
    output logic [31:0]              cfu_req_data1,
    output logic [$clog2(DEPTH)-1:0] cfu_req_id,
    output logic                     cfu_req_cfu_csr,
    input  logic                     cfu_resp_valid,
    output logic                     cfu_resp_ready,
    input  logic [$clog2(DEPTH)-1:0] cfu_resp_id,
    input  logic [31:0]              cfu_resp_data,
    input  logic [2:0]               cfu_resp_status,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [31:0]              wb_data,
    output logic [TAG_W-1:0]         wb_tag,
    output logic                     wb_error,
    output logic                     spurious_resp
);
    localparam int ID_W = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t            state;
    logic [DEPTH-1:0]  slot_valid;
    logic [TAG_W-1:0]  slot_tag [DEPTH];
    logic [ID_W-1:0]   free_idx;
    logic [ID_W-1:0]   low_idx;
    logic              any_free;
    logic              any_valid;
    logic              issue_fire;
    logic              resp_fire;
    logic              resp_hit;
    logic              wb_fire;
    logic              wb_flush;
    logic [ID_W-1:0]   flush_idx;
    logic              flush_load;
    logic              flush_free;

    // Priority encoders: lowest free slot for allocation, lowest valid slot for flush.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        low_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_idx = ID_W'(i);
                any_free = 1'b1;
            end
            if (slot_valid[i]) begin
                low_idx = ID_W'(i);
            end
        end
    end

    assign any_valid  = |slot_valid;
    assign issue_fire = issue_valid && issue_ready;
    assign resp_fire  = cfu_resp_valid && cfu_resp_ready;
    assign resp_hit   = slot_valid[cfu_resp_id];
    assign wb_fire    = wb_valid && wb_ready;
    assign flush_load = (state == S_FLUSH) && !wb_valid && any_valid;
    assign flush_free = wb_fire && wb_flush;

`ifdef CFU_REQUESTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            next_state;
    logic [WD_W-1:0]   wd_cnt;
    logic              wd_hit;

    assign wd_hit = (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (wd_hit) next_state = S_FLUSH;
            S_FLUSH: if (!any_valid) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Watchdog only advances while requests sit outstanding with nothing left to send.
    always_ff @(posedge clk) begin
        if (rst || state == S_FLUSH || resp_fire || !any_valid || wd_hit) begin
            wd_cnt <= '0;
        end else if (!cfu_req_valid) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign state = S_IDLE;
`endif

    always_comb begin
        issue_ready    = !rst && any_free && (!cfu_req_valid || cfu_req_ready)
                         && (state != S_FLUSH);
        cfu_resp_ready = !rst && (!wb_valid || wb_ready) && (state != S_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_tag[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((resp_fire && resp_hit && cfu_resp_id == ID_W'(i)) ||
                    (flush_free && flush_idx == ID_W'(i))) begin
                    slot_valid[i] <= 1'b0;
                end
                if (issue_fire && free_idx == ID_W'(i)) begin
                    slot_valid[i] <= 1'b1;
                    slot_tag[i]   <= issue_tag;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfu_req_valid   <= 1'b0;
            cfu_req_insn    <= '0;
            cfu_req_data0   <= '0;
            cfu_req_data1   <= '0;
            cfu_req_id      <= '0;
            cfu_req_cfu_csr <= 1'b0;
        end else if (issue_fire) begin
            cfu_req_valid   <= 1'b1;
            cfu_req_insn    <= issue_insn;
            cfu_req_data0   <= issue_rs1;
            cfu_req_data1   <= issue_rs2;
            cfu_req_id      <= free_idx;
            cfu_req_cfu_csr <= issue_csr;
        end else if (cfu_req_ready) begin
            cfu_req_valid   <= 1'b0;
        end
    end

    // Response capture and flush error writebacks never coincide: responses are blocked in FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_tag        <= '0;
            wb_error      <= 1'b0;
            wb_flush      <= 1'b0;
            flush_idx     <= '0;
            spurious_resp <= 1'b0;
        end else begin
            spurious_resp <= resp_fire && !resp_hit;
            if (resp_fire && resp_hit) begin
                wb_valid <= 1'b1;
                wb_data  <= cfu_resp_data;
                wb_tag   <= slot_tag[cfu_resp_id];
                wb_error <= (cfu_resp_status != 3'd0);
                wb_flush <= 1'b0;
            end else if (flush_load) begin
                wb_valid  <= 1'b1;
                wb_data   <= '0;
                wb_tag    <= slot_tag[low_idx];
                wb_error  <= 1'b1;
                wb_flush  <= 1'b1;
                flush_idx <= low_idx;
            end else if (wb_fire) begin
                wb_valid <= 1'b0;
                wb_flush <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cfu_requester.sv
// tb/tb_cfu_requester.sv - directed self-checking bench for cfu_requester.
module tb_cfu_requester;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready;
    logic [31:0] issue_insn, issue_rs1, issue_rs2;
    logic [4:0]  issue_tag;
    logic        issue_csr;
    logic        cfu_req_valid, cfu_req_ready;
    logic [31:0] cfu_req_insn, cfu_req_data0, cfu_req_data1;
    logic [1:0]  cfu_req_id;
    logic        cfu_req_cfu_csr;
    logic        cfu_resp_valid, cfu_resp_ready;
    logic [1:0]  cfu_resp_id;
    logic [31:0] cfu_resp_data;
    logic [2:0]  cfu_resp_status;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;
    logic        wb_error;
    logic        spurious_resp;

    int checks = 0;
    int errors = 0;

    cfu_requester #(.DEPTH(4), .TAG_W(5), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_insn(issue_insn), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_tag(issue_tag), .issue_csr(issue_csr),
        .cfu_req_valid(cfu_req_valid), .cfu_req_ready(cfu_req_ready),
        .cfu_req_insn(cfu_req_insn), .cfu_req_data0(cfu_req_data0),
        .cfu_req_data1(cfu_req_data1), .cfu_req_id(cfu_req_id),
        .cfu_req_cfu_csr(cfu_req_cfu_csr),
        .cfu_resp_valid(cfu_resp_valid), .cfu_resp_ready(cfu_resp_ready),
        .cfu_resp_id(cfu_resp_id), .cfu_resp_data(cfu_resp_data),
        .cfu_resp_status(cfu_resp_status),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_tag(wb_tag), .wb_error(wb_error), .spurious_resp(spurious_resp)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_issue(input logic v, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [4:0] tag);
        issue_valid = v;
        issue_insn  = 32'h0000_000B ^ {27'd0, tag};
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_tag   = tag;
        issue_csr   = 1'b0;
    endtask

    task automatic set_resp(input logic v, input logic [1:0] id, input logic [31:0] data,
                            input logic [2:0] status);
        cfu_resp_valid  = v;
        cfu_resp_id     = id;
        cfu_resp_data   = data;
        cfu_resp_status = status;
    endtask

    initial begin
        rst = 1'b1;
        cfu_req_ready = 1'b0;
        wb_ready = 1'b1;
        set_issue(1'b0, 0, 0, 0);
        set_resp(1'b0, 0, 0, 0);
        cyc();
        cyc();
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_req_valid", cfu_req_valid, 0);
        chk("rst_resp_ready", cfu_resp_ready, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_req_id", cfu_req_id, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_spurious", spurious_resp, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_issue_ready", issue_ready, 1);

        // single op
        cfu_req_ready = 1'b1;
        set_issue(1'b1, 5, 7, 3);
        cyc();
        set_issue(1'b0, 0, 0, 0);
        chk("op_req_valid", cfu_req_valid, 1);
        chk("op_req_data0", cfu_req_data0, 5);
        chk("op_req_data1", cfu_req_data1, 7);
        chk("op_req_id", cfu_req_id, 0);
        chk("op_req_insn", cfu_req_insn, 32'h0000_0008);
        set_resp(1'b1, 0, 12, 0);
        cyc();
        set_resp(1'b0, 0, 0, 0);
        chk("op_wb_valid", wb_valid, 1);
        chk("op_wb_data", wb_data, 12);
        chk("op_wb_tag", wb_tag, 3);
        chk("op_wb_error", wb_error, 0);
        cyc();
        chk("op_wb_drain", wb_valid, 0);

        // fill all four slots back to back
        for (int i = 0; i < 4; i++) begin
            set_issue(1'b1, 32'(i), 0, 5'(10 + i));
            cyc();
            chk("fill_req_id", cfu_req_id, 32'(i));
        end
        set_issue(1'b0, 0, 0, 0);
        #1;
        chk("full_issue_ready", issue_ready, 0);

        // out of order: slot 2 then slot 0
        set_resp(1'b1, 2, 32'h22, 0);
        cyc();
        chk("ooo_issue_ready_after_free", issue_ready, 1);
        chk("ooo_wb_tag_a", wb_tag, 12);
        chk("ooo_wb_data_a", wb_data, 32'h22);
        set_resp(1'b1, 0, 32'h33, 5);
        cyc();
        set_resp(1'b0, 0, 0, 0);
        chk("ooo_wb_tag_b", wb_tag, 10);
        chk("ooo_wb_data_b", wb_data, 32'h33);
        chk("ooo_wb_error_b", wb_error, 1);
        cyc();
        chk("ooo_drain", wb_valid, 0);

        // writeback backpressure
        wb_ready = 1'b0;
        set_resp(1'b1, 3, 32'h44, 0);
        cyc();
        set_resp(1'b1, 1, 32'h55, 0);
        #1;
        chk("bp_resp_ready", cfu_resp_ready, 0);
        cyc();
        cyc();
        chk("bp_wb_valid", wb_valid, 1);
        chk("bp_wb_data_stable", wb_data, 32'h44);
        chk("bp_wb_tag_stable", wb_tag, 13);
        wb_ready = 1'b1;
        #1;
        chk("bp_release_resp_ready", cfu_resp_ready, 1);
        cyc();
        set_resp(1'b0, 0, 0, 0);
        chk("bp_next_wb_data", wb_data, 32'h55);
        chk("bp_next_wb_tag", wb_tag, 11);
        cyc();
        chk("bp_drain", wb_valid, 0);

        // spurious response to empty slot 1
        set_resp(1'b1, 1, 32'h66, 0);
        cyc();
        set_resp(1'b0, 0, 0, 0);
        chk("spur_pulse", spurious_resp, 1);
        chk("spur_no_wb", wb_valid, 0);
        cyc();
        chk("spur_pulse_end", spurious_resp, 0);

        // reset mid-operation discards the outstanding request
        cfu_req_ready = 1'b0;
        set_issue(1'b1, 32'hABCD, 1, 7);
        cyc();
        set_issue(1'b0, 0, 0, 0);
        cyc();
        chk("hold_req_valid", cfu_req_valid, 1);
        chk("hold_req_data0", cfu_req_data0, 32'hABCD);
        rst = 1'b1;
        #1;
        chk("midrst_issue_ready", issue_ready, 0);
        cyc();
        chk("midrst_req_valid", cfu_req_valid, 0);
        rst = 1'b0;
        set_resp(1'b1, 0, 32'h77, 0);
        cyc();
        set_resp(1'b0, 0, 0, 0);
        chk("midrst_slot_dropped", spurious_resp, 1);
        chk("midrst_no_wb", wb_valid, 0);

`ifdef CFU_REQUESTER_TIMEOUT_EN
        begin
            int n;
            cfu_req_ready = 1'b1;
            set_issue(1'b1, 1, 1, 20);
            cyc();
            set_issue(1'b1, 2, 2, 21);
            cyc();
            set_issue(1'b0, 0, 0, 0);
            n = 0;
            for (int k = 1; k <= 40; k++) begin
                cyc();
                if (wb_valid) begin
                    n = k;
                    break;
                end
            end
            chk("to_first_wb_cycle", n, 18);
            chk("to_flush_issue_ready", issue_ready, 0);
            chk("to_wb_tag_a", wb_tag, 20);
            chk("to_wb_error_a", wb_error, 1);
            chk("to_wb_data_a", wb_data, 0);
            cyc();
            n = 0;
            for (int k = 1; k <= 10; k++) begin
                if (wb_valid) begin
                    n = k;
                    break;
                end
                cyc();
            end
            chk("to_second_wb_seen", (n != 0), 1);
            chk("to_wb_tag_b", wb_tag, 21);
            chk("to_wb_error_b", wb_error, 1);
            cyc();
            cyc();
            chk("to_back_idle", issue_ready, 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
